// File: rtl/debounced_input_pio.sv
// Avalon-MM input PIO: per-bit synchroniser and debouncer, sticky edge capture and level irq.
// Define DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN to capture releases as well as presses.

module debounced_input_pio_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic deb_o
);
    logic                 sync1_q, sync2_q;
    logic                 deb_q, deb_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Any sample that matches the accepted level restarts the stability count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module debounced_input_pio #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_async,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             irq
);
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_dly_q;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      rdata_q, rdata_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounced_input_pio_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .pin_i  (in_async[g]),
            .deb_o  (deb[g])
        );
    end

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^avs_writedata[31:WIDTH];
    end

`ifdef DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN
    assign edge_w = deb_dly_q ^ deb;
`else
    assign edge_w = deb_dly_q & ~deb;
`endif

    // A new edge is OR-ed in after the write-1-to-clear so a same-cycle set wins.
    always_comb begin
        cap_d   = cap_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        if (avs_write) begin
            case (avs_address)
                2'd1:    mask_d = avs_writedata[WIDTH-1:0];
                2'd3:    cap_d  = cap_q & ~avs_writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        cap_d = cap_d | edge_w;
        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = 32'(deb);
                2'd1:    rdata_d = 32'(mask_q);
                2'd3:    rdata_d = 32'(cap_q);
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_dly_q <= '1;
            cap_q     <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
        end else begin
            deb_dly_q <= deb;
            cap_q     <= cap_d;
            mask_q    <= mask_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = |(cap_q & mask_q);
endmodule

// File: tb/tb_debounced_input_pio.sv
// Directed bench for debounced_input_pio with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_debounced_input_pio;
    localparam int W = 4;
    localparam int D = 4;
`ifdef DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [W-1:0] in_async;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        irq;
    logic [31:0] rd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    debounced_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_async     (in_async),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] v);
        avs_address   = a;
        avs_writedata = v;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic chk_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        reset_n = 1'b0; in_async = 4'hF; avs_address = 2'd0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tick(); tick();
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk_read("idle_data", 2'd0, 32'hF);
        chk_read("idle_cap", 2'd3, 32'h0);
        chk_read("idle_mask", 2'd1, 32'h0);

        // 3-clock glitch on bit 1 never reaches the accept count
        in_async[1] = 1'b0;
        repeat (3) tick();
        in_async[1] = 1'b1;
        repeat (10) tick();
        chk_read("glitch_data", 2'd0, 32'hF);
        chk_read("glitch_cap", 2'd3, 32'h0);
        check("glitch_irq", {31'd0, irq}, 32'd0);

        do_write(2'd1, 32'h1);
        chk_read("mask_rd", 2'd1, 32'h1);
        do_write(2'd0, 32'h0);
        do_write(2'd2, 32'hFFFF_FFFF);
        chk_read("wr0_ignored", 2'd0, 32'hF);
        chk_read("rd2_zero", 2'd2, 32'h0);

        // press bit 0: debounced after edge 6, capture/irq after edge 7
        in_async[0] = 1'b0;
        repeat (5) tick();
        check("irq_pre", {31'd0, irq}, 32'd0);
        do_read(2'd0, rd);
        check("deb_e6", rd, 32'hF);
        check("irq_e6", {31'd0, irq}, 32'd0);
        do_read(2'd0, rd);
        check("deb_e7", rd, 32'hE);
        check("irq_set", {31'd0, irq}, 32'd1);
        chk_read("cap_set", 2'd3, 32'h1);

        do_write(2'd3, 32'h0);
        chk_read("clr0_noeff", 2'd3, 32'h1);
        check("irq_hold", {31'd0, irq}, 32'd1);

        // read and write of the mask in the same cycle returns the old value
        avs_address = 2'd1; avs_writedata = 32'h0; avs_write = 1'b1; avs_read = 1'b1;
        tick();
        avs_write = 1'b0; avs_read = 1'b0;
        check("rw_prewrite", avs_readdata, 32'h1);
        check("irq_masked", {31'd0, irq}, 32'd0);
        chk_read("mask_zero", 2'd1, 32'h0);
        do_write(2'd1, 32'h1);
        check("irq_unmask", {31'd0, irq}, 32'd1);

        do_write(2'd3, 32'h1);
        check("irq_clr", {31'd0, irq}, 32'd0);
        chk_read("cap_clr", 2'd3, 32'h0);

        in_async[0] = 1'b1;
        repeat (10) tick();
        chk_read("rel_data", 2'd0, 32'hF);
        chk_read("rise_cap0", 2'd3, BOTH ? 32'h1 : 32'h0);
        do_write(2'd3, 32'hF);

        // clear lands on the same edge that captures a new fall
        in_async[0] = 1'b0;
        repeat (6) tick();
        do_write(2'd3, 32'h1);
        chk_read("collision", 2'd3, 32'h1);
        check("irq_coll", {31'd0, irq}, 32'd1);

        in_async[2] = 1'b0;
        repeat (10) tick();
        do_write(2'd3, 32'hF);
        in_async[2] = 1'b1;
        repeat (6) tick();
        do_read(2'd3, rd);
        check("rise_cap_e7", rd, 32'h0);
        do_read(2'd3, rd);
        check("rise_cap2", rd, BOTH ? 32'h4 : 32'h0);
        chk_read("data_b0low", 2'd0, 32'hE);

        in_async[0] = 1'b1;
        repeat (10) tick();
        do_write(2'd3, 32'hF);
        do_write(2'd1, 32'hF);
        in_async = 4'hC;
        repeat (10) tick();
        chk_read("cap_03", 2'd3, 32'h3);
        check("irq_03", {31'd0, irq}, 32'd1);

        // asynchronous reset between clock edges
        #2 reset_n = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_rdata", avs_readdata, 32'd0);
        in_async = 4'hF;
        tick(); tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk_read("post_data", 2'd0, 32'hF);
        chk_read("post_mask", 2'd1, 32'h0);
        chk_read("post_cap", 2'd3, 32'h0);
        check("post_irq", {31'd0, irq}, 32'd0);

        // pin held low through reset gives exactly one capture
        reset_n = 1'b0;
        in_async[3] = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (5) tick();
        do_read(2'd0, rd);
        check("held_e6", rd, 32'hF);
        do_read(2'd0, rd);
        check("held_e7", rd, 32'h7);
        chk_read("held_cap", 2'd3, 32'h8);
        repeat (10) tick();
        chk_read("held_once", 2'd3, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
